pipe_mux_n: RTL and testbench
=============================

PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
Parameters:
REQ-001 WIDTH, 32, data width of every input lane and the output, in bits.
REQ-002 N_IN, 4, number of input lanes; legal range 2..16.
REQ-003 SEL_W, $clog2(N_IN), width of the select field; derived, never overridden.
Ports:
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_data  input  N_IN*WIDTH  flat lanes; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_sel  input  SEL_W  lane index to capture.
REQ-009 in_valid  input  1  upstream offers in_data/in_sel.
REQ-010 in_ready  output  1  block can accept; registered output.
REQ-011 out_data  output  WIDTH  selected lane value at the head of the buffer.
REQ-012 out_sel  output  SEL_W  in_sel value that produced out_data.
REQ-013 out_valid  output  1  out_data/out_sel are valid.
REQ-014 out_ready  input  1  downstream accepts the head entry.
REQ-015 sel_err  output  1  one-cycle pulse when an out-of-range select is accepted.

Function
REQ-016 Accept occurs on a cycle with in_valid && in_ready && !flush.
REQ-017 Accepted entry = {lane in_sel of in_data, in_sel}, sampled at that edge.
REQ-018 Latency: an entry accepted at edge t is visible on out_data/out_valid after edge t when the buffer was empty.
REQ-019 Pop occurs on a cycle with out_valid && out_ready && !flush.
REQ-020 Buffer: 2 entries (head + skid), strict FIFO order, no entry dropped or duplicated.
REQ-021 FSM states: EMPTY (0 entries), ONE (1 entry), TWO (2 entries).
REQ-022 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-023 ONE: accept and pop -> ONE, new entry becomes head; accept only -> TWO; pop only -> EMPTY; neither -> ONE.
REQ-024 TWO: pop -> ONE, skid becomes head; no pop -> TWO. No accept is possible in TWO.
REQ-025 in_ready is 1 in EMPTY and ONE and 0 in TWO, registered from the next state.
REQ-026 out_valid is 1 in ONE and TWO and 0 in EMPTY.
REQ-027 Sustained in_valid=1 with out_ready=1 yields one entry per cycle (full throughput).
REQ-028 While out_valid=1 and out_ready=0, out_data and out_sel hold constant.
REQ-029 If in_sel >= N_IN (possible only when N_IN is not a power of two), the stored data is all zeros and sel_err=1 for exactly the cycle after the accept.
REQ-030 sel_err is 0 on every other cycle.
REQ-031 flush=1 has priority: next state is EMPTY, the same-cycle input is discarded, no pop is counted, out_valid=0 and in_ready=1 on the next cycle.
REQ-032 Head register contents hold their last value when the FSM is EMPTY; they are don't-care for checking whenever out_valid=0.

Reset
REQ-033 With rst_n=0 at an edge: state=EMPTY, out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=0.
REQ-034 On the first edge after rst_n returns to 1, in_ready becomes 1.
REQ-035 rst_n has priority over flush and over any handshake; reset mid-transfer discards all entries.

Structure
REQ-036 Package pipe_mux_pkg holds the state enum (EMPTY, ONE, TWO) and the default WIDTH and N_IN constants.
REQ-037 Lane selection is one combinational sub-module, mux_n (parameters WIDTH, N_IN), which outputs zero for an out-of-range select.
REQ-038 No latches; all storage is clocked by clk.

Verification
REQ-039 Directed scenarios:
- Reset, then lanes {0x11111111, 0x22222222, 0x33333333, 0x44444444}, in_sel=2, in_valid=1, out_ready=1 -> out_data=0x33333333, out_sel=2 one edge later.
- out_ready=0, push 0xA then 0xB -> in_ready=0 after the second accept; out_data holds 0xA; set out_ready=1 -> 0xA then 0xB in order.
- 10 back-to-back accepts with out_ready=1 -> 10 pops on consecutive cycles, in_ready stays 1.
- N_IN=3, accept with in_sel=3 -> out_data=0, sel_err high for exactly one cycle.
- In state TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears at the output.
- rst_n=0 mid-stream in state TWO -> next cycle outputs match REQ-033; after release, first accept behaves per REQ-018.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// Shared types and defaults for the pipelined N-way lane selector.
package pipe_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N_IN  = 4;

endpackage

// File: rtl/pipe_mux_n_mux.sv
// Combinational N-way lane selector; out-of-range selects yield zero with o_hit low.
module mux_n
  import pipe_mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N_IN  = DEFAULT_N_IN,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_hit
);

  always_comb begin
    o_data = '0;
    o_hit  = 1'b0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*WIDTH +: WIDTH];
        o_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// Lane selector feeding a two-entry (head + skid) FIFO with valid/ready handshakes.
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N_IN  = DEFAULT_N_IN,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_head_data;
  logic [SEL_W-1:0]   r_head_sel;
  logic [WIDTH-1:0]   r_skid_data;
  logic [SEL_W-1:0]   r_skid_sel;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_sel_err;

  logic [WIDTH-1:0]   w_lane;
  logic               w_hit;
  logic               w_accept;
  logic               w_pop;

  mux_n #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_lane),
    .o_hit  (w_hit)
  );

  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_pop    = r_out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_head_data <= '0;
      r_head_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sel_err <= w_accept && !w_hit;
      if (flush) begin
        r_state     <= EMPTY;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          EMPTY: begin
            r_in_ready <= 1'b1;
            if (w_accept) begin
              r_head_data <= w_lane;
              r_head_sel  <= in_sel;
              r_state     <= ONE;
              r_out_valid <= 1'b1;
            end
          end
          ONE: begin
            if (w_accept && w_pop) begin
              r_head_data <= w_lane;
              r_head_sel  <= in_sel;
            end else if (w_accept) begin
              r_skid_data <= w_lane;
              r_skid_sel  <= in_sel;
              r_state     <= TWO;
              r_in_ready  <= 1'b0;
            end else if (w_pop) begin
              r_state     <= EMPTY;
              r_out_valid <= 1'b0;
            end
          end
          TWO: begin
            // in_ready is low here, so the only possible event is a pop.
            if (w_pop) begin
              r_head_data <= r_skid_data;
              r_head_sel  <= r_skid_sel;
              r_state     <= ONE;
              r_in_ready  <= 1'b1;
            end
          end
          default: begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_head_data;
  assign out_sel   = r_head_sel;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed self-checking bench for pipe_mux_n (4-lane and 3-lane instances).
module tb_pipe_mux_n;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         flush;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;

  logic         flush3;
  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;
  logic         out_ready3;
  logic         sel_err3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(32), .N_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  pipe_mux_n #(.WIDTH(32), .N_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [31:0] l0, input logic [31:0] l1,
                           input logic [31:0] l2, input logic [31:0] l3);
    in_data = {l3, l2, l1, l0};
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    flush3 = 1'b0; in_data3 = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;

    // Reset state
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    check("rst_sel_err",   64'(sel_err),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready",  64'(in_ready),  64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Basic select of lane 2
    set_lanes(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("s1_out_valid", 64'(out_valid), 64'd1);
    check("s1_out_data",  64'(out_data),  64'h33333333);
    check("s1_out_sel",   64'(out_sel),   64'd2);
    check("s1_sel_err",   64'(sel_err),   64'd0);
    step();
    check("s1_drained", 64'(out_valid), 64'd0);

    // Backpressure: fill head and skid, then drain in order
    out_ready = 1'b0;
    set_lanes(32'hA, 32'hB, 32'h0, 32'h0);
    in_sel = 2'd0; in_valid = 1'b1;
    step();
    check("s2_a_data",  64'(out_data), 64'hA);
    check("s2_a_ready", 64'(in_ready), 64'd1);
    in_sel = 2'd1;
    step();
    in_valid = 1'b0;
    check("s2_full_ready", 64'(in_ready),  64'd0);
    check("s2_full_data",  64'(out_data),  64'hA);
    check("s2_full_valid", 64'(out_valid), 64'd1);
    step();
    check("s2_hold_data", 64'(out_data), 64'hA);
    check("s2_hold_sel",  64'(out_sel),  64'd0);
    out_ready = 1'b1;
    step();
    check("s2_b_data",  64'(out_data),  64'hB);
    check("s2_b_sel",   64'(out_sel),   64'd1);
    check("s2_b_valid", 64'(out_valid), 64'd1);
    check("s2_b_ready", 64'(in_ready),  64'd1);
    step();
    check("s2_empty", 64'(out_valid), 64'd0);

    // Ten back-to-back transfers at full throughput
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 0; i < 10; i++) begin
      set_lanes(32'h100 + 32'(i), 32'h0, 32'h0, 32'h0);
      step();
      check("s3_data",  64'(out_data),  64'h100 + 64'(i));
      check("s3_valid", 64'(out_valid), 64'd1);
      check("s3_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    check("s3_drained", 64'(out_valid), 64'd0);

    // Flush in TWO with a simultaneous offer
    out_ready = 1'b0; in_valid = 1'b1;
    set_lanes(32'hA, 32'hB, 32'h0, 32'h0);
    in_sel = 2'd0; step();
    in_sel = 2'd1; step();
    check("s5_full", 64'(in_ready), 64'd0);
    set_lanes(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("s5_flush_valid", 64'(out_valid), 64'd0);
    check("s5_flush_ready", 64'(in_ready),  64'd1);
    step();
    check("s5_after_valid", 64'(out_valid), 64'd0);
    // Flush in ONE while an accept is offered
    set_lanes(32'hC, 32'h0, 32'h0, 32'h0);
    in_sel = 2'd0; in_valid = 1'b1;
    step();
    check("s5b_one_data", 64'(out_data), 64'hC);
    set_lanes(32'hEEEE, 32'hEEEE, 32'hEEEE, 32'hEEEE);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("s5b_flush_valid", 64'(out_valid), 64'd0);
    check("s5b_flush_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    check("s5b_after_valid", 64'(out_valid), 64'd0);

    // Reset mid-stream while in TWO
    out_ready = 1'b0; in_valid = 1'b1;
    set_lanes(32'h5, 32'h6, 32'h0, 32'h0);
    in_sel = 2'd0; step();
    in_sel = 2'd1; step();
    check("s6_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    check("s6_rst_valid", 64'(out_valid), 64'd0);
    check("s6_rst_data",  64'(out_data),  64'd0);
    check("s6_rst_sel",   64'(out_sel),   64'd0);
    check("s6_rst_err",   64'(sel_err),   64'd0);
    check("s6_rst_ready", 64'(in_ready),  64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("s6_rel_ready", 64'(in_ready),  64'd1);
    check("s6_rel_valid", 64'(out_valid), 64'd0);
    set_lanes(32'h0, 32'h0, 32'h0, 32'h77777777);
    in_sel = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("s6_first_valid", 64'(out_valid), 64'd1);
    check("s6_first_data",  64'(out_data),  64'h77777777);
    check("s6_first_sel",   64'(out_sel),   64'd3);
    out_ready = 1'b1;
    step();
    check("s6_drained", 64'(out_valid), 64'd0);

    // Three-lane instance: out-of-range select
    in_data3 = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    out_ready3 = 1'b1; in_sel3 = 2'd3; in_valid3 = 1'b1;
    step();
    check("s4_err_pulse", 64'(sel_err3),   64'd1);
    check("s4_oob_data",  64'(out_data3),  64'd0);
    check("s4_oob_sel",   64'(out_sel3),   64'd3);
    check("s4_oob_valid", 64'(out_valid3), 64'd1);
    in_sel3 = 2'd2;
    step();
    in_valid3 = 1'b0;
    check("s4_err_clear", 64'(sel_err3),  64'd0);
    check("s4_lane2",     64'(out_data3), 64'hCCCC0003);
    step();
    check("s4_err_idle", 64'(sel_err3),   64'd0);
    check("s4_drained",  64'(out_valid3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1);
  end

endmodule
